// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - AXI4-Lite initiator with independent read/write FSMs and per-direction timeout
module axi4_lite_master #(
  parameter int Addr_Width     = 32,
  parameter int Data_Width     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  aclk_i,
  input  logic                  areset_i,
  input  logic                  wr_req_i,
  input  logic                  rd_req_i,
  input  logic [Addr_Width-1:0] req_addr_i,
  input  logic [Data_Width-1:0] req_wdata_i,
  output logic                  wr_busy_o,
  output logic                  rd_busy_o,
  output logic                  wr_done_o,
  output logic                  wr_err_o,
  output logic                  rd_done_o,
  output logic                  rd_err_o,
  output logic [Data_Width-1:0] rd_data_o,
  output logic [Addr_Width-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [Data_Width-1:0] wdata_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic [Addr_Width-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [Data_Width-1:0] rdata_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [Addr_Width-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [Data_Width-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  wr_done_q, wr_done_d, wr_err_q, wr_err_d, wr_busy_q, wr_busy_d;
  logic                  rd_done_q, rd_done_d, rd_err_q, rd_err_d, rd_busy_q, rd_busy_d;
  logic [TW-1:0]         wr_timer_q, wr_timer_d, rd_timer_q, rd_timer_d;
  logic [TW-1:0]         wr_timer_inc, rd_timer_inc;
  logic                  wr_tmo, rd_tmo;

  // Busy also covers the done-pulse cycle so a request arriving with the pulse is ignored.
  always_comb begin
    w_state_d    = w_state_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    wr_done_d    = 1'b0;
    wr_err_d     = 1'b0;
    wr_timer_d   = wr_timer_q;
    wr_timer_inc = wr_timer_q + TW'(1);
    wr_tmo       = (TIMEOUT_CYCLES != 0) && (wr_timer_inc == TO_LIM);
    case (w_state_q)
      W_IDLE: begin
        if (wr_req_i && !wr_busy_q) begin
          awaddr_d   = req_addr_i;
          wdata_d    = req_wdata_i;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_timer_d = '0;
          w_state_d  = W_ADDR;
        end
      end
      W_ADDR: begin
        awvalid_d = awvalid_q & ~awready_i;
        wvalid_d  = wvalid_q & ~wready_i;
        if (!awvalid_d && !wvalid_d) begin
          bready_d   = 1'b1;
          wr_timer_d = '0;
          w_state_d  = W_RESP;
        end else if ((awvalid_q && awready_i) || (wvalid_q && wready_i)) begin
          wr_timer_d = '0;
        end else if (wr_tmo) begin
          awvalid_d  = 1'b0;
          wvalid_d   = 1'b0;
          wr_done_d  = 1'b1;
          wr_err_d   = 1'b1;
          wr_timer_d = '0;
          w_state_d  = W_IDLE;
        end else begin
          wr_timer_d = wr_timer_inc;
        end
      end
      W_RESP: begin
        if (bvalid_i || wr_tmo) begin
          bready_d   = 1'b0;
          wr_done_d  = 1'b1;
          wr_err_d   = ~bvalid_i;
          wr_timer_d = '0;
          w_state_d  = W_IDLE;
        end else begin
          wr_timer_d = wr_timer_inc;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    wr_busy_d = (w_state_d != W_IDLE) || wr_done_d;
  end

  // RREADY rises together with ARVALID; a response on the address edge completes the read.
  always_comb begin
    r_state_d    = r_state_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rd_data_d    = rd_data_q;
    rd_done_d    = 1'b0;
    rd_err_d     = 1'b0;
    rd_timer_d   = rd_timer_q;
    rd_timer_inc = rd_timer_q + TW'(1);
    rd_tmo       = (TIMEOUT_CYCLES != 0) && (rd_timer_inc == TO_LIM);
    case (r_state_q)
      R_IDLE: begin
        if (rd_req_i && !rd_busy_q) begin
          araddr_d   = req_addr_i;
          arvalid_d  = 1'b1;
          rready_d   = 1'b1;
          rd_timer_d = '0;
          r_state_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (arready_i) begin
          arvalid_d  = 1'b0;
          rd_timer_d = '0;
          if (rvalid_i) begin
            rd_data_d = rdata_i;
            rready_d  = 1'b0;
            rd_done_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_state_d = R_DATA;
          end
        end else if (rd_tmo) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b0;
          rd_done_d  = 1'b1;
          rd_err_d   = 1'b1;
          rd_timer_d = '0;
          r_state_d  = R_IDLE;
        end else begin
          rd_timer_d = rd_timer_inc;
        end
      end
      R_DATA: begin
        if (rvalid_i || rd_tmo) begin
          if (rvalid_i) rd_data_d = rdata_i;
          rready_d   = 1'b0;
          rd_done_d  = 1'b1;
          rd_err_d   = ~rvalid_i;
          rd_timer_d = '0;
          r_state_d  = R_IDLE;
        end else begin
          rd_timer_d = rd_timer_inc;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    rd_busy_d = (r_state_d != R_IDLE) || rd_done_d;
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
      rd_data_q  <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      wr_busy_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_busy_q  <= 1'b0;
      wr_timer_q <= '0;
      rd_timer_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      araddr_q   <= araddr_d;
      rd_data_q  <= rd_data_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      wr_done_q  <= wr_done_d;
      wr_err_q   <= wr_err_d;
      wr_busy_q  <= wr_busy_d;
      rd_done_q  <= rd_done_d;
      rd_err_q   <= rd_err_d;
      rd_busy_q  <= rd_busy_d;
      wr_timer_q <= wr_timer_d;
      rd_timer_q <= rd_timer_d;
    end
  end

  assign wr_busy_o = wr_busy_q;
  assign rd_busy_o = rd_busy_q;
  assign wr_done_o = wr_done_q;
  assign wr_err_o  = wr_err_q;
  assign rd_done_o = rd_done_q;
  assign rd_err_o  = rd_err_q;
  assign rd_data_o = rd_data_q;
  assign awaddr_o  = awaddr_q;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;
  assign araddr_o  = araddr_q;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - bench for axi4_lite_master: delay-programmable slave, scoreboard, cycle sequences
module tb_axi4_lite_master;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        wr_busy, rd_busy, wr_done, wr_err, rd_done, rd_err;
  logic [31:0] rd_data, awaddr, wdata, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  axi4_lite_master #(.Addr_Width(32), .Data_Width(32), .TIMEOUT_CYCLES(8)) dut (
    .aclk_i(clk), .areset_i(areset), .wr_req_i(wr_req), .rd_req_i(rd_req),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .wr_busy_o(wr_busy), .rd_busy_o(rd_busy), .wr_done_o(wr_done), .wr_err_o(wr_err),
    .rd_done_o(rd_done), .rd_err_o(rd_err), .rd_data_o(rd_data),
    .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wvalid_o(wvalid), .wready_i(wready),
    .bvalid_i(bvalid), .bready_o(bready),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rvalid_i(rvalid), .rready_o(rready)
  );

  int n_cmp = 0, n_bad = 0;
  int n_wr_done = 0, n_rd_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave delays count negedges with the relevant VALID/READY visible.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [31:0] s_rdata = '0;

  initial begin : slave
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit ar_acc;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; ar_acc = 0;
    forever begin
      @(negedge clk);
      if (!awvalid) begin awready = 0; aw_cnt = 0; end
      else if (!awready) begin if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++; end
      if (!wvalid) begin wready = 0; w_cnt = 0; end
      else if (!wready) begin if (w_cnt >= w_dly) wready = 1; else w_cnt++; end
      if (!bready) begin bvalid = 0; b_cnt = 0; end
      else if (!bvalid) begin if (b_cnt >= b_dly) bvalid = 1; else b_cnt++; end
      if (!rready) begin rvalid = 0; ar_acc = 0; r_cnt = 0; end
      else if (ar_acc && !rvalid) begin
        if (r_cnt >= r_dly) begin rvalid = 1; rdata = s_rdata; end else r_cnt++;
      end
      if (!arvalid) begin arready = 0; ar_cnt = 0; end
      else if (!arready) begin
        if (ar_cnt >= ar_dly) begin arready = 1; ar_acc = 1; end else ar_cnt++;
      end
    end
  end

  typedef struct { bit err; logic [31:0] data; } exp_t;
  exp_t wr_exp[$], rd_exp[$];
  logic [31:0] last_rd = '0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!areset && wr_done) begin
        n_wr_done++;
        if (wr_exp.size() == 0) check("unexpected_wr_done", 1, 0);
        else begin e = wr_exp.pop_front(); check("wr_err", wr_err, e.err); end
      end
      if (!areset && rd_done) begin
        n_rd_done++;
        if (rd_exp.size() == 0) check("unexpected_rd_done", 1, 0);
        else begin
          e = rd_exp.pop_front();
          check("rd_err", rd_err, e.err);
          check("rd_data", rd_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                       input logic [31:0] wd, input bit wr_e, input bit rd_e, input logic [31:0] rd_v);
    exp_t e;
    wr_req = do_wr; rd_req = do_rd; req_addr = addr; req_wdata = wd;
    if (do_wr) begin e.err = wr_e; e.data = '0; wr_exp.push_back(e); end
    if (do_rd) begin
      if (!rd_e) last_rd = rd_v;
      e.err = rd_e; e.data = last_rd; rd_exp.push_back(e);
    end
    tick();
    wr_req = 0; rd_req = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((wr_busy || rd_busy) && n < 100) begin tick(); n++; end
    check(name, {wr_busy, rd_busy}, 2'b00);
  endtask

  typedef struct {
    bit do_wr; bit do_rd; logic [31:0] addr; logic [31:0] wd; logic [31:0] rd_v;
    int aw_d; int w_d; int b_d; int ar_d; int r_d; bit wr_e; bit rd_e;
  } vec_t;
  vec_t vecs[11];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : test
    int c, hi;
    bit seen;
    vecs[0]  = '{1, 0, 32'h100, 32'h1111_1111, 32'h0,         0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 32'h104, 32'h2222_2222, 32'h0,         2, 5, 1, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 32'h108, 32'h3333_3333, 32'h0,         7, 0, 7, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 32'h10C, 32'h4444_4444, 32'h0,         8, 8, 0, 0, 0, 1, 0};
    vecs[4]  = '{1, 0, 32'h110, 32'h5555_5555, 32'h0,         0, 0, 8, 0, 0, 1, 0};
    vecs[5]  = '{0, 1, 32'h200, 32'h0,         32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 32'h204, 32'h0,         32'h0BAD_F00D, 0, 0, 0, 7, 7, 0, 0};
    vecs[7]  = '{0, 1, 32'h208, 32'h0,         32'hFFFF_0000, 0, 0, 0, 8, 0, 0, 1};
    vecs[8]  = '{0, 1, 32'h20C, 32'h0,         32'h1357_9BDF, 0, 0, 0, 0, 8, 0, 1};
    vecs[9]  = '{1, 1, 32'h300, 32'hCAFE_0001, 32'h600D_0001, 1, 3, 2, 2, 1, 0, 0};
    vecs[10] = '{1, 1, 32'h304, 32'hCAFE_0002, 32'h0DD0_0002, 0, 1, 0, 9, 0, 0, 1};

    repeat (3) tick();
    check("rst_ctrl", {wr_busy, rd_busy, wr_done, wr_err, rd_done, rd_err,
                       awvalid, wvalid, bready, arvalid, rready}, 11'b0);
    check("rst_rd_data", rd_data, 0);
    check("rst_awaddr_wdata", {awaddr, wdata}, 64'h0);
    check("rst_araddr", araddr, 0);
    areset = 0;
    tick();

    // Write, both address and data accepted at cycle 2, response at cycle 3
    aw_dly = 1; w_dly = 1; b_dly = 0;
    issue(1, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0);
    check("t1_c1_valid", {awvalid, wvalid, bready}, 3'b110);
    check("t1_c1_addr_data", {awaddr, wdata}, {32'h10, 32'hDEAD_BEEF});
    tick();
    check("t1_c2_valid", {awvalid, wvalid, bready}, 3'b110);
    tick();
    check("t1_c3_bready", {awvalid, wvalid, bready, wr_done}, 4'b0010);
    tick();
    check("t1_c4_done", {wr_done, wr_err, bready, wr_busy}, 4'b1001);
    tick();
    check("t1_c5_idle", {wr_busy, wr_done}, 2'b00);

    // Split handshakes: address at cycle 1, data at cycle 4
    aw_dly = 0; w_dly = 3; b_dly = 0;
    issue(1, 0, 32'h14, 32'h0000_5A5A, 0, 0, 0);
    check("t2_c1", {awvalid, wvalid, bready}, 3'b110);
    tick();
    check("t2_c2", {awvalid, wvalid, bready}, 3'b010);
    tick(); tick();
    check("t2_c4", {awvalid, wvalid, bready}, 3'b010);
    tick();
    check("t2_c5", {awvalid, wvalid, bready}, 3'b001);
    wait_idle("t2_idle");

    // Read with early RREADY
    ar_dly = 1; r_dly = 0; s_rdata = 32'h1234_5678;
    issue(0, 1, 32'h20, 0, 0, 0, 32'h1234_5678);
    check("t3_c1", {arvalid, rready, araddr}, {2'b11, 32'h20});
    tick();
    check("t3_c2", {arvalid, rready}, 2'b11);
    tick();
    check("t3_c3", {arvalid, rready, rd_done}, 3'b010);
    tick();
    check("t3_c4", {rready, rd_done, rd_err, rd_data}, {3'b010, 32'h1234_5678});
    wait_idle("t3_idle");

    for (int i = 0; i < 11; i++) begin
      aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; b_dly = vecs[i].b_d;
      ar_dly = vecs[i].ar_d; r_dly = vecs[i].r_d; s_rdata = vecs[i].rd_v;
      issue(vecs[i].do_wr, vecs[i].do_rd, vecs[i].addr, vecs[i].wd,
            vecs[i].wr_e, vecs[i].rd_e, vecs[i].rd_v);
      check($sformatf("vec%0d_busy", i), {wr_busy, rd_busy}, {vecs[i].do_wr, vecs[i].do_rd});
      wait_idle($sformatf("vec%0d_idle", i));
    end

    // Read timeout: ARREADY never comes
    ar_dly = 1000;
    issue(0, 1, 32'h40, 0, 0, 1, 0);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (arvalid) hi++;
      tick();
    end
    check("t5_arvalid_cycles", hi, 8);
    check("t5_end", {arvalid, rready, rd_done, rd_err}, 4'b0011);
    check("t5_rd_data_kept", rd_data, last_rd);
    wait_idle("t5_idle");

    // Concurrent read and write; re-request while busy is dropped
    c = n_wr_done; hi = n_rd_done;
    aw_dly = 2; w_dly = 2; b_dly = 1; ar_dly = 3; r_dly = 2; s_rdata = 32'hBEEF_0040;
    issue(1, 1, 32'h30, 32'h0000_0030, 0, 0, 32'hBEEF_0040);
    check("t4_concurrent", {awvalid, wvalid, arvalid, rready}, 4'b1111);
    wr_req = 1; req_addr = 32'h99; req_wdata = 32'h99;
    tick();
    wr_req = 0;
    check("t4_awaddr_kept", awaddr, 32'h30);
    wait_idle("t4_idle");
    tick();
    check("t4_done_counts", {n_wr_done - c, n_rd_done - hi}, {32'd1, 32'd1});

    // Request arriving with the done pulse is ignored
    aw_dly = 0; w_dly = 0; b_dly = 0;
    issue(1, 0, 32'h50, 32'h50, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (wr_done) seen = 1; else tick();
    end
    check("t7_done_seen", seen, 1);
    wr_req = 1; req_addr = 32'h77;
    tick();
    wr_req = 0;
    check("t7_req_ignored", {wr_busy, awvalid}, 2'b00);

    // Reset in the middle of a write
    aw_dly = 1000; w_dly = 1000;
    c = n_wr_done;
    issue(1, 0, 32'h60, 32'h6060_6060, 0, 0, 0);
    check("t6_c1_valid", awvalid, 1);
    areset = 1;
    tick();
    check("t6_rst_ctrl", {wr_busy, wr_done, awvalid, wvalid, bready, rd_busy}, 6'b0);
    check("t6_rst_regs", {awaddr, rd_data}, 64'h0);
    wr_exp.delete();
    last_rd = '0;
    areset = 0;
    repeat (3) tick();
    check("t6_no_done", n_wr_done - c, 0);
    aw_dly = 0; w_dly = 1; b_dly = 2;
    issue(1, 0, 32'h64, 32'h6464_6464, 0, 0, 0);
    check("t6_restart_addr", {awaddr, wdata}, {32'h64, 32'h6464_6464});
    wait_idle("t6_idle");
    tick();
    check("t6_done_after", n_wr_done - c, 1);

    check("sb_wr_empty", wr_exp.size(), 0);
    check("sb_rd_empty", rd_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
